// File: rtl/m_tile_scan_if.sv
// Tile request and pixel beat handshake bundle for m_tile_scan.
// The slave modport is the scanner's view; the master modport is the requester/sink view.
interface m_tile_scan_if #(
    parameter int TILE_LOG2 = 5,
    parameter int MAP_BITS  = 4,
    parameter int COLOR_W   = 12
);
    localparam int XW = MAP_BITS + TILE_LOG2;
    localparam int YW = XW + 1;

    logic                req_valid;
    logic                req_ready;
    logic [MAP_BITS-1:0] req_map_x;
    logic [MAP_BITS-1:0] req_map_y;
    logic [COLOR_W-1:0]  req_color;

    logic                pix_valid;
    logic                pix_ready;
    logic [XW-1:0]       pixel_xpos;
    logic [YW-1:0]       pixel_ypos;
    logic [COLOR_W-1:0]  pix_color;
    logic                pix_last;
    logic                busy;

    modport slave (
        input  req_valid, req_map_x, req_map_y, req_color, pix_ready,
        output req_ready, pix_valid, pixel_xpos, pixel_ypos, pix_color, pix_last, busy
    );

    modport master (
        output req_valid, req_map_x, req_map_y, req_color, pix_ready,
        input  req_ready, pix_valid, pixel_xpos, pixel_ypos, pix_color, pix_last, busy
    );
endinterface

// File: rtl/m_tile_scan.sv
// Walks every pixel of one map tile, emitting row-major (x fastest) pixel beats with the request colour.
// First beat one cycle after request accept; pix_* hold while pix_ready is low; one idle bubble between tiles.
module m_tile_scan #(
    parameter int TILE_LOG2 = 5,
    parameter int MAP_BITS  = 4,
    parameter int COLOR_W   = 12
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    m_tile_scan_if.slave  bus
);
    typedef enum logic {IDLE, SCAN} state_e;

    localparam logic [TILE_LOG2-1:0] OFF_MAX = '1;
    localparam logic [TILE_LOG2-1:0] OFF_PEN = TILE_LOG2'((2 ** TILE_LOG2) - 2);

    state_e                state_q, state_d;
    logic [MAP_BITS-1:0]   map_x_q, map_x_d;
    logic [MAP_BITS-1:0]   map_y_q, map_y_d;
    logic [COLOR_W-1:0]    color_q, color_d;
    logic [TILE_LOG2-1:0]  x_off_q, x_off_d;
    logic [TILE_LOG2-1:0]  y_off_q, y_off_d;
    logic                  req_ready_q, req_ready_d;
    logic                  pix_valid_q, pix_valid_d;
    logic                  pix_last_q, pix_last_d;
    logic                  busy_q, busy_d;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q     <= IDLE;
            map_x_q     <= '0;
            map_y_q     <= '0;
            color_q     <= '0;
            x_off_q     <= '0;
            y_off_q     <= '0;
            req_ready_q <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            map_x_q     <= map_x_d;
            map_y_q     <= map_y_d;
            color_q     <= color_d;
            x_off_q     <= x_off_d;
            y_off_q     <= y_off_d;
            req_ready_q <= req_ready_d;
            pix_valid_q <= pix_valid_d;
            pix_last_q  <= pix_last_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        map_x_d     = map_x_q;
        map_y_d     = map_y_q;
        color_d     = color_q;
        x_off_d     = x_off_q;
        y_off_d     = y_off_q;
        req_ready_d = req_ready_q;
        pix_valid_d = pix_valid_q;
        pix_last_d  = pix_last_q;
        busy_d      = busy_q;

        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                pix_valid_d = 1'b0;
                pix_last_d  = 1'b0;
                busy_d      = 1'b0;
                if (bus.req_valid && req_ready_q) begin
                    map_x_d     = bus.req_map_x;
                    map_y_d     = bus.req_map_y;
                    color_d     = bus.req_color;
                    x_off_d     = '0;
                    y_off_d     = '0;
                    state_d     = SCAN;
                    req_ready_d = 1'b0;
                    pix_valid_d = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            SCAN: begin
                if (pix_valid_q && bus.pix_ready) begin
                    if (pix_last_q) begin
                        state_d     = IDLE;
                        pix_valid_d = 1'b0;
                        pix_last_d  = 1'b0;
                        busy_d      = 1'b0;
                        req_ready_d = 1'b1;
                    end else begin
                        x_off_d = x_off_q + 1'b1;
                        if (x_off_q == OFF_MAX) begin
                            y_off_d = y_off_q + 1'b1;
                        end
                        // Flag the beat that will be presented next, so pix_last stays registered.
                        pix_last_d = (x_off_q == OFF_PEN) && (y_off_q == OFF_MAX);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.pix_valid  = pix_valid_q;
    assign bus.pix_last   = pix_last_q;
    assign bus.busy       = busy_q;
    assign bus.pix_color  = color_q;
    assign bus.pixel_xpos = {map_x_q, x_off_q};
    assign bus.pixel_ypos = {1'b0, map_y_q, y_off_q};

    // A stalled beat must stay put until the sink takes it.
    a_stall_hold: assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
        (bus.pix_valid && !bus.pix_ready) |=>
            (bus.pix_valid && $stable(bus.pixel_xpos) && $stable(bus.pixel_ypos)
             && $stable(bus.pix_color) && $stable(bus.pix_last)));

    a_busy_valid: assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
        bus.busy == bus.pix_valid);

    a_no_overlap: assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
        !(bus.busy && bus.req_ready));

endmodule

// File: tb/tb_m_tile_scan.sv
// Tile scanner bench: reset, table of tile requests with a pixel-order reference model, overlap and mid-scan reset.
module tb_m_tile_scan;
    localparam int TILE_LOG2 = 5;
    localparam int MAP_BITS  = 4;
    localparam int COLOR_W   = 12;
    localparam int TILE      = 32;
    localparam int BEATS     = TILE * TILE;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    always #5 sys_clk = ~sys_clk;

    m_tile_scan_if #(.TILE_LOG2(TILE_LOG2), .MAP_BITS(MAP_BITS), .COLOR_W(COLOR_W)) bus ();

    m_tile_scan #(.TILE_LOG2(TILE_LOG2), .MAP_BITS(MAP_BITS), .COLOR_W(COLOR_W)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    typedef struct {
        int mx;
        int my;
        int col;
        bit stall;
        bit raise_next;
        int nx;
        int ny;
        int ncol;
        int fx;
        int fy;
        int lx;
        int ly;
    } vec_t;

    vec_t vecs [5];
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int outs_or();
        return int'(bus.req_ready) | int'(bus.pix_valid) | int'(bus.pix_last) | int'(bus.busy)
             | int'(bus.pixel_xpos) | int'(bus.pixel_ypos) | int'(bus.pix_color);
    endfunction

    // Entered and left just after a falling edge.
    task automatic run_tile(input vec_t v);
        int k, cyc, beat_err, stall_err, rdy_err;
        int fx, fy, lx, ly, px, py, pc, pl, ex, ey;
        bit prev_stall, rdy;
        cyc = 0;
        while (!bus.req_ready && cyc < 50) begin
            @(negedge sys_clk);
            cyc++;
        end
        check("req_ready before accept", int'(bus.req_ready), 1);
        bus.req_valid = 1'b1;
        bus.req_map_x = MAP_BITS'(v.mx);
        bus.req_map_y = MAP_BITS'(v.my);
        bus.req_color = COLOR_W'(v.col);
        @(negedge sys_clk);
        bus.req_valid = 1'b0;
        check("req_ready after accept", int'(bus.req_ready), 0);
        check("first beat latency", int'(bus.pix_valid), 1);
        k = 0; cyc = 0; beat_err = 0; stall_err = 0; rdy_err = 0;
        fx = -1; fy = -1; lx = -1; ly = -1; px = 0; py = 0; pc = 0; pl = 0;
        prev_stall = 1'b0;
        while (k < BEATS && cyc < 20000) begin
            if (prev_stall && (!bus.pix_valid || int'(bus.pixel_xpos) != px || int'(bus.pixel_ypos) != py
                               || int'(bus.pix_color) != pc || int'(bus.pix_last) != pl))
                stall_err++;
            if (bus.req_ready) rdy_err++;
            if (v.raise_next && k == 500) begin
                bus.req_valid = 1'b1;
                bus.req_map_x = MAP_BITS'(v.nx);
                bus.req_map_y = MAP_BITS'(v.ny);
                bus.req_color = COLOR_W'(v.ncol);
            end
            rdy = v.stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.pix_ready = rdy;
            if (bus.pix_valid) begin
                ex = v.mx * TILE + (k % TILE);
                ey = v.my * TILE + (k / TILE);
                if (int'(bus.pixel_xpos) != ex || int'(bus.pixel_ypos) != ey
                    || int'(bus.pix_color) != v.col || int'(bus.pix_last) != int'(k == BEATS - 1))
                    beat_err++;
                if (k == 0) begin
                    fx = int'(bus.pixel_xpos);
                    fy = int'(bus.pixel_ypos);
                end
                if (rdy) begin
                    if (k == BEATS - 1) begin
                        lx = int'(bus.pixel_xpos);
                        ly = int'(bus.pixel_ypos);
                    end
                    k++;
                end
            end
            prev_stall = bus.pix_valid && !rdy;
            px = int'(bus.pixel_xpos); py = int'(bus.pixel_ypos);
            pc = int'(bus.pix_color);  pl = int'(bus.pix_last);
            @(negedge sys_clk);
            cyc++;
        end
        bus.pix_ready = 1'($urandom_range(0, 1));
        check("accepted beats", k, BEATS);
        check("beat vs model errors", beat_err, 0);
        check("stall hold violations", stall_err, 0);
        check("req_ready while scanning", rdy_err, 0);
        check("first beat x", fx, v.fx);
        check("first beat y", fy, v.fy);
        check("last beat x", lx, v.lx);
        check("last beat y", ly, v.ly);
        check("pix_valid after tile", int'(bus.pix_valid), 0);
        check("busy after tile", int'(bus.busy), 0);
        check("pix_last after tile", int'(bus.pix_last), 0);
        check("req_ready after tile", int'(bus.req_ready), 1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rv;
        vecs[0] = '{3,  5,  'hF00, 1'b0, 1'b0, 0, 0, 0,     96,  160, 127, 191};
        vecs[1] = '{3,  5,  'hF00, 1'b1, 1'b0, 0, 0, 0,     96,  160, 127, 191};
        vecs[2] = '{15, 15, 'hABC, 1'b1, 1'b0, 0, 0, 0,     480, 480, 511, 511};
        vecs[3] = '{0,  0,  'h123, 1'b0, 1'b1, 1, 1, 'h456, 0,   0,   31,  31};
        vecs[4] = '{1,  1,  'h456, 1'b1, 1'b0, 0, 0, 0,     32,  32,  63,  63};

        bus.req_valid = 1'b0;
        bus.req_map_x = '0;
        bus.req_map_y = '0;
        bus.req_color = '0;
        bus.pix_ready = 1'b1;

        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            check("outputs in reset", outs_or(), 0);
        end
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        check("req_ready after release", int'(bus.req_ready), 1);
        check("pix_valid after release", int'(bus.pix_valid), 0);

        for (int i = 0; i < 5; i++) begin
            run_tile(vecs[i]);
        end

        // Abort a tile partway with reset, then scan a fresh one.
        bus.req_valid = 1'b1;
        bus.req_map_x = 4'd7;
        bus.req_map_y = 4'd9;
        bus.req_color = 12'h0F0;
        @(negedge sys_clk);
        bus.req_valid = 1'b0;
        bus.pix_ready = 1'b1;
        repeat (100) @(negedge sys_clk);
        check("beat 100 x", int'(bus.pixel_xpos), 7 * TILE + 100 % TILE);
        check("beat 100 y", int'(bus.pixel_ypos), 9 * TILE + 100 / TILE);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        check("pix_valid on reset edge", int'(bus.pix_valid), 0);
        check("busy on reset edge", int'(bus.busy), 0);
        check("outputs on reset edge", outs_or(), 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        check("req_ready after mid reset", int'(bus.req_ready), 1);
        check("pix_valid after mid reset", int'(bus.pix_valid), 0);
        rv = '{2, 2, 'h777, 1'b1, 1'b0, 0, 0, 0, 64, 64, 95, 95};
        run_tile(rv);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
